// File: rtl/ivector_say_arbiter.sv
// ivector_say_arbiter: round-robin sharing of one IVector say FIFO enqueue port.
// Each requester owns a one-entry buffer so its ready never depends on its enable;
// one buffered word per cycle moves into a registered hold stage tagged with its source.
module ivector_say_arbiter #(
   parameter int unsigned WIDTH = 704,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned TAGW  = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NREQ-1:0]       request_say__ENA,
   input  logic [NREQ*WIDTH-1:0] request_say_v,
   output logic [NREQ-1:0]       request_say__RDY,
   output logic                  fifo_enq__ENA,
   output logic [WIDTH-1:0]      fifo_enq_v,
   output logic [TAGW-1:0]       fifo_enq_tag,
   input  logic                  fifo_enq__RDY
);

   logic [NREQ-1:0]  r_buf_valid;
   logic [WIDTH-1:0] r_buf_data [NREQ];
   logic [TAGW-1:0]  r_ptr;
   logic             r_hold_valid;
   logic [WIDTH-1:0] r_hold_data;
   logic [TAGW-1:0]  r_hold_tag;

   logic             w_drain;
   logic             w_slot;
   logic             w_any;
   logic [NREQ-1:0]  w_sel;
   logic [TAGW-1:0]  w_win;
   logic [TAGW-1:0]  w_ptr_next;
   logic [WIDTH-1:0] w_win_data;

   assign w_drain = r_hold_valid && fifo_enq__RDY;
   assign w_slot  = !r_hold_valid || w_drain;

   // Round-robin search starting at r_ptr; first valid buffer wins when the hold stage frees.
   always_comb begin
      int p;
      p          = 0;
      w_sel      = '0;
      w_any      = 1'b0;
      w_win      = '0;
      w_win_data = '0;
      if (w_slot) begin
         for (int k = 0; k < int'(NREQ); k++) begin
            p = int'(r_ptr) + k;
            if (p >= int'(NREQ)) begin
               p = p - int'(NREQ);
            end
            for (int i = 0; i < int'(NREQ); i++) begin
               if (!w_any && (i == p) && r_buf_valid[i]) begin
                  w_any      = 1'b1;
                  w_sel[i]   = 1'b1;
                  w_win      = TAGW'(i);
                  w_win_data = r_buf_data[i];
               end
            end
         end
      end
   end

   // Explicit wrap compare so non-power-of-two NREQ works.
   always_comb begin
      w_ptr_next = (w_win == TAGW'(NREQ - 1)) ? '0 : w_win + TAGW'(1);
   end

   assign request_say__RDY = ~r_buf_valid | w_sel;
   assign fifo_enq__ENA    = w_drain;
   assign fifo_enq_v       = r_hold_data;
   assign fifo_enq_tag     = r_hold_tag;

   // Per-requester buffers: a refill wins over a select so select-and-refill keeps the word flowing.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_buf_valid <= '0;
         for (int i = 0; i < int'(NREQ); i++) begin
            r_buf_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NREQ); i++) begin
            if (request_say__ENA[i]) begin
               r_buf_valid[i] <= 1'b1;
               r_buf_data[i]  <= request_say_v[i*WIDTH +: WIDTH];
            end else if (w_sel[i]) begin
               r_buf_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Hold stage and pointer: load on selection, empty on drain, pointer frozen otherwise.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
         r_hold_tag   <= '0;
         r_ptr        <= '0;
      end else begin
         if (w_any) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= w_win_data;
            r_hold_tag   <= w_win;
            r_ptr        <= w_ptr_next;
         end else if (w_drain) begin
            r_hold_valid <= 1'b0;
         end
      end
   end

endmodule
